// File: rtl/lane_init_ctrl.sv
// lane_init_ctrl: sideband-domain link-initialisation sequencer.
// Steps the lane through Disconnect -> Wait-Connect -> TS1 -> TS2 -> CL0,
// with a Disabled state. It drives the timer's control inputs and consumes
// the timer's timeout flags. Flags from the slow clk_b domain are
// resynchronised here. Every output is registered and decoded from the
// next state, so outputs move on the same edge as state_o.
module lane_init_ctrl #(
  parameter int unsigned MAX_RETRY = 3,    // 1..15
  parameter bit          GEN4_EN   = 1'b1
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       disable_req,
  input  logic       ts1_done,
  input  logic       ts2_done,
  input  logic       tconnect_rx_min,
  input  logic       tdisconnect_rx_min,
  input  logic       ttraining_error_timeout,
  input  logic       tdisconnect_tx_min,
  input  logic       tdisabled_min,
  input  logic       tgen4_ts1_timeout,
  input  logic       tgen4_ts2_timeout,
  output logic       disconnected_s,
  output logic       fsm_disabled,
  output logic       fsm_training,
  output logic       ts1_gen4_s,
  output logic       ts2_gen4_s,
  output logic       send_ts1,
  output logic       send_ts2,
  output logic       link_up,
  output logic       link_fail,
  output logic [2:0] state_o
);

  localparam int NUM_SYNC = 4;

  typedef enum logic [2:0] {
    S_DISC = 3'd0,
    S_WAIT = 3'd1,
    S_TS1  = 3'd2,
    S_TS2  = 3'd3,
    S_CL0  = 3'd4,
    S_DIS  = 3'd5
  } state_t;

  // clk_b flags: [0] tdisconnect_tx_min, [1] tdisabled_min,
  // [2] tgen4_ts1_timeout, [3] tgen4_ts2_timeout
  logic [NUM_SYNC-1:0]      w_async;
  logic [NUM_SYNC-1:0][1:0] r_sync;
  logic [NUM_SYNC-1:0]      w_sync;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_retry_cnt;
  logic [3:0] w_retry_inc;
  logic       w_fail;
  logic       w_exhaust;

  assign w_async = {tgen4_ts2_timeout, tgen4_ts1_timeout,
                    tdisabled_min, tdisconnect_tx_min};

  // Two-flop synchroniser per flag. Only the level is used, because each
  // flag is held for a full clk_b period, which is far longer than two
  // sb_clk periods.
  for (genvar g = 0; g < NUM_SYNC; g++) begin : g_sync
    always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) r_sync[g] <= 2'b00;
      else      r_sync[g] <= {r_sync[g][0], w_async[g]};
    end
    assign w_sync[g] = r_sync[g][1];
  end

  // Saturating retry increment and the exhaustion test used on a failure
  assign w_retry_inc = (r_retry_cnt == 4'hF) ? 4'hF : r_retry_cnt + 4'd1;
  assign w_exhaust   = (w_retry_inc >= 4'(MAX_RETRY));

  // Next-state decode. disable_req is checked first, then failures and
  // timeouts, then progress, so a timeout beats a done in the same cycle.
  always_comb begin
    w_next = r_state;
    w_fail = 1'b0;
    case (r_state)
      S_DISC: begin
        if (disable_req)    w_next = S_DIS;
        else if (w_sync[0]) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (disable_req)             w_next = S_DIS;
        else if (tdisconnect_rx_min) w_next = S_DISC;
        else if (tconnect_rx_min)    w_next = S_TS1;
      end
      S_TS1: begin
        if (disable_req)                               w_next = S_DIS;
        else if (w_sync[2] || ttraining_error_timeout) w_fail = 1'b1;
        else if (ts1_done)                             w_next = S_TS2;
      end
      S_TS2: begin
        if (disable_req)                               w_next = S_DIS;
        else if (w_sync[3] || ttraining_error_timeout) w_fail = 1'b1;
        else if (ts2_done)                             w_next = S_CL0;
      end
      S_CL0: begin
        if (disable_req)             w_next = S_DIS;
        else if (tdisconnect_rx_min) w_next = S_DISC;
      end
      S_DIS: begin
        if (w_sync[1] && !disable_req) w_next = S_DISC;
      end
      default: w_next = S_DISC;
    endcase
    if (w_fail) w_next = w_exhaust ? S_DIS : S_DISC;
  end

  // State, retry bookkeeping and registered outputs decoded from w_next
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_DISC;
      r_retry_cnt    <= 4'd0;
      link_fail      <= 1'b0;
      disconnected_s <= 1'b1;
      fsm_disabled   <= 1'b0;
      fsm_training   <= 1'b0;
      ts1_gen4_s     <= 1'b0;
      ts2_gen4_s     <= 1'b0;
      send_ts1       <= 1'b0;
      send_ts2       <= 1'b0;
      link_up        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_fail) begin
        r_retry_cnt <= w_retry_inc;
        if (w_exhaust) link_fail <= 1'b1;
      end else if (w_next == S_CL0 && r_state != S_CL0) begin
        r_retry_cnt <= 4'd0;
        link_fail   <= 1'b0;
      end else if (r_state == S_DIS && w_next == S_DISC) begin
        r_retry_cnt <= 4'd0;
      end
      disconnected_s <= (w_next == S_DISC) || (w_next == S_DIS);
      fsm_disabled   <= (w_next == S_DIS);
      // Both training states keep this high so the training budget in the
      // timer runs without a gap across TS1 -> TS2
      fsm_training   <= (w_next == S_TS1) || (w_next == S_TS2);
      ts1_gen4_s     <= GEN4_EN && (w_next == S_TS1);
      ts2_gen4_s     <= GEN4_EN && (w_next == S_TS2);
      send_ts1       <= (w_next == S_TS1);
      send_ts2       <= (w_next == S_TS2);
      link_up        <= (w_next == S_CL0);
    end
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_lane_init_ctrl.sv
// tb_lane_init_ctrl: table-driven directed bench for lane_init_ctrl
// (MAX_RETRY=3, GEN4_EN=1) plus hand sequences for retry count,
// disable-vs-done collision and asynchronous reset.
`timescale 1ns/1ps
module tb_lane_init_ctrl;

  logic sb_clk = 1'b0;
  logic rst = 1'b0;
  logic disable_req, ts1_done, ts2_done, tconnect_rx_min, tdisconnect_rx_min;
  logic ttraining_error_timeout, tdisconnect_tx_min, tdisabled_min;
  logic tgen4_ts1_timeout, tgen4_ts2_timeout;
  logic disconnected_s, fsm_disabled, fsm_training, ts1_gen4_s, ts2_gen4_s;
  logic send_ts1, send_ts2, link_up, link_fail;
  logic [2:0] state_o;

  int total = 0;
  int bad = 0;

  lane_init_ctrl #(.MAX_RETRY(3), .GEN4_EN(1'b1)) dut (
    .sb_clk(sb_clk), .rst(rst),
    .disable_req(disable_req), .ts1_done(ts1_done), .ts2_done(ts2_done),
    .tconnect_rx_min(tconnect_rx_min), .tdisconnect_rx_min(tdisconnect_rx_min),
    .ttraining_error_timeout(ttraining_error_timeout),
    .tdisconnect_tx_min(tdisconnect_tx_min), .tdisabled_min(tdisabled_min),
    .tgen4_ts1_timeout(tgen4_ts1_timeout), .tgen4_ts2_timeout(tgen4_ts2_timeout),
    .disconnected_s(disconnected_s), .fsm_disabled(fsm_disabled),
    .fsm_training(fsm_training), .ts1_gen4_s(ts1_gen4_s), .ts2_gen4_s(ts2_gen4_s),
    .send_ts1(send_ts1), .send_ts2(send_ts2), .link_up(link_up),
    .link_fail(link_fail), .state_o(state_o)
  );

  always #500 sb_clk = ~sb_clk;

  // Input bits: dis t1d t2d crx drx terr dtx tdm g1 g2
  localparam logic [9:0] I_NONE = 10'b0000000000;
  localparam logic [9:0] I_DIS  = 10'b1000000000;
  localparam logic [9:0] I_T1D  = 10'b0100000000;
  localparam logic [9:0] I_T2D  = 10'b0010000000;
  localparam logic [9:0] I_CRX  = 10'b0001000000;
  localparam logic [9:0] I_DRX  = 10'b0000100000;
  localparam logic [9:0] I_TERR = 10'b0000010000;
  localparam logic [9:0] I_DTX  = 10'b0000001000;
  localparam logic [9:0] I_TDM  = 10'b0000000100;
  localparam logic [9:0] I_G1   = 10'b0000000010;

  // Output bits: disc fsm_dis train ts1g ts2g send1 send2 link_up link_fail
  localparam logic [8:0] O_DISC = 9'b100000000;
  localparam logic [8:0] O_WAIT = 9'b000000000;
  localparam logic [8:0] O_TS1  = 9'b001101000;
  localparam logic [8:0] O_TS2  = 9'b001010100;
  localparam logic [8:0] O_CL0  = 9'b000000010;
  localparam logic [8:0] O_DIS  = 9'b110000000;
  localparam logic [8:0] LF     = 9'b000000001;

  typedef struct {
    logic [9:0] in;
    int         n;
    logic [8:0] eo;
    logic [2:0] st;
  } vec_t;

  vec_t vq[$];

  function automatic logic [11:0] obs();
    return {disconnected_s, fsm_disabled, fsm_training, ts1_gen4_s, ts2_gen4_s,
            send_ts1, send_ts2, link_up, link_fail, state_o};
  endfunction

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] v);
    {disable_req, ts1_done, ts2_done, tconnect_rx_min, tdisconnect_rx_min,
     ttraining_error_timeout, tdisconnect_tx_min, tdisabled_min,
     tgen4_ts1_timeout, tgen4_ts2_timeout} = v;
  endtask

  task automatic run(input string nm, input logic [9:0] iv, input int n,
                     input logic [8:0] eo, input logic [2:0] st);
    drive(iv);
    repeat (n) @(posedge sb_clk);
    #1;
    chk(nm, obs(), {eo, st});
  endtask

  task automatic add(input logic [9:0] iv, input int n, input logic [8:0] eo,
                     input logic [2:0] st);
    vq.push_back('{in: iv, n: n, eo: eo, st: st});
  endtask

  initial begin
    drive(I_NONE);
    // bring-up: CDC latency 3 clk on tdisconnect_tx_min
    add(I_DTX, 2, O_DISC, 3'd0);
    add(I_DTX, 1, O_WAIT, 3'd1);
    add(I_CRX, 1, O_TS1, 3'd2);
    add(I_NONE, 1, O_TS1, 3'd2);
    add(I_T1D, 1, O_TS2, 3'd3);
    add(I_T2D, 1, O_CL0, 3'd4);
    add(I_NONE, 2, O_CL0, 3'd4);
    add(I_DRX, 1, O_DISC, 3'd0);
    // three TS1 timeouts exhaust retries
    add(I_DTX, 3, O_WAIT, 3'd1);
    add(I_CRX, 1, O_TS1, 3'd2);
    add(I_G1, 2, O_TS1, 3'd2);
    add(I_G1, 1, O_DISC, 3'd0);
    add(I_DTX, 3, O_WAIT, 3'd1);
    add(I_CRX, 1, O_TS1, 3'd2);
    add(I_G1, 3, O_DISC, 3'd0);
    add(I_DTX, 3, O_WAIT, 3'd1);
    add(I_CRX, 1, O_TS1, 3'd2);
    add(I_G1, 3, O_DIS | LF, 3'd5);
    // disabled exit needs disable_req low
    add(I_DIS | I_TDM, 4, O_DIS | LF, 3'd5);
    add(I_TDM, 1, O_DISC | LF, 3'd0);
    add(I_DTX, 3, O_WAIT | LF, 3'd1);
    add(I_CRX, 1, O_TS1 | LF, 3'd2);
    add(I_T1D, 1, O_TS2 | LF, 3'd3);
    add(I_T2D, 1, O_CL0, 3'd4);
    add(I_DRX, 1, O_DISC, 3'd0);
    // done and timeout together in TS2: timeout wins
    add(I_DTX, 3, O_WAIT, 3'd1);
    add(I_CRX, 1, O_TS1, 3'd2);
    add(I_T1D, 1, O_TS2, 3'd3);
    add(I_T2D | I_TERR, 1, O_DISC, 3'd0);

    // reset state
    repeat (2) @(posedge sb_clk);
    #1;
    chk("reset", obs(), {O_DISC, 3'd0});
    rst = 1'b1;

    for (int i = 0; i < vq.size(); i++)
      run($sformatf("vec%0d", i), vq[i].in, vq[i].n, vq[i].eo, vq[i].st);

    chk("retry_after_ts2_fail", {8'd0, dut.r_retry_cnt}, 12'd1);

    // back to CL0 clears retry, then disconnect
    run("h_wait", I_DTX, 3, O_WAIT, 3'd1);
    run("h_ts1", I_CRX, 1, O_TS1, 3'd2);
    run("h_ts2", I_T1D, 1, O_TS2, 3'd3);
    run("h_cl0", I_T2D, 1, O_CL0, 3'd4);
    chk("retry_cl0_clear", {8'd0, dut.r_retry_cnt}, 12'd0);
    run("h_cl0_drx", I_DRX, 1, O_DISC, 3'd0);

    // disable_req beats ts1_done
    run("h2_wait", I_DTX, 3, O_WAIT, 3'd1);
    run("h2_ts1", I_CRX, 1, O_TS1, 3'd2);
    run("dis_vs_ts1done", I_DIS | I_T1D, 1, O_DIS, 3'd5);

    // asynchronous reset mid-cycle
    #300;
    rst = 1'b0;
    #10;
    chk("async_reset", obs(), {O_DISC, 3'd0});
    chk("async_reset_retry", {8'd0, dut.r_retry_cnt}, 12'd0);
    drive(I_NONE);
    @(posedge sb_clk);
    #1;
    rst = 1'b1;
    run("post_reset_idle", I_NONE, 3, O_DISC, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
